fetch_aligner: RTL and testbench
================================

// Module: fetch_aligner
// PURPOSE
//  Realigns the 32-bit fetch word stream into whole instructions for compressed_decoder.
//  Handles 16-bit instructions and 32-bit instructions that straddle a word boundary,
//  redirects after a flush, and tags each instruction with its PC.
//  Sits between the instruction-fetch port and compressed_decoder: instr_o drives its instr_i,
//  and instr_valid_o drives its valid_i.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first PC after reset; bit 0 must be 0
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   asynchronous reset, active-high
//  fetch_addr_o   out  32  word address of next fetch, bits[1:0]=00
//  fetch_valid_i  in   1   fetch_rdata_i/fetch_err_i valid
//  fetch_ready_o  out  1   aligner accepts a word this cycle
//  fetch_rdata_i  in   32  fetched word, little-endian halfwords
//  fetch_err_i    in   1   bus error on this word
//  flush_i        in   1   redirect: discard buffered data and restart at flush_pc_i
//  flush_pc_i     in   32  redirect target; bit 0 ignored (treated as 0)
//  instr_valid_o  out  1   instr_o/instr_pc_o/instr_err_o valid
//  instr_ready_i  in   1   downstream consumes instruction
//  instr_o        out  32  raw instruction; compressed form zero-extended {16'b0,hw}
//  instr_pc_o     out  32  PC of instr_o
//  instr_err_o    out  1   a halfword of this instruction carried fetch_err_i
// BEHAVIOUR
//  State
//   - Halfword queue hw[0..2], each 16 data bits plus an err bit; count 0..3.
//   - pc register; skip_low flag; fetch_addr register.
//  Reset (async)
//   - count=0, pc=RESET_PC, fetch_addr_o={RESET_PC[31:2],2'b00}, skip_low=RESET_PC[1].
//   - instr_valid_o=0, fetch_ready_o=0 while rst_i is high.
//  Fetch side
//   - fetch_ready_o = (count<=1) & ~flush_i. Registered state only; no path from instr_ready_i.
//   - Accept when fetch_valid_i & fetch_ready_o.
//   - On accept, append hw lo then hi, both with err=fetch_err_i.
//   - If skip_low is set, append hi only and clear skip_low.
//   - On accept, fetch_addr_o += 4; it wraps at 2^32.
//  Output side
//   - avail is true when any of the following holds:
//     - count>=1 and hw[0][1:0]!=2'b11;
//     - count>=2;
//     - count>=1 and hw[0].err.
//   - instr_valid_o = avail & ~flush_i.
//   - Outputs are derived from registers only: a word accepted at edge N is visible in cycle N+1.
//   - Output contents:
//     - hw[0][1:0]!=11: instr_o={16'b0,hw[0]}, size 2.
//     - Otherwise: instr_o={hw[1],hw[0]}, size 4.
//     - Err head with count==1: instr_o={16'b0,hw[0]}, size 2.
//   - instr_err_o = OR of err over the consumed halfwords. instr_pc_o=pc.
//   - A transfer occurs on instr_valid_o & instr_ready_i.
//   - On a transfer: pop size/2 halfwords; pc += size, mod 2^32.
//   - A held instruction (valid & ~ready) keeps instr_o, instr_pc_o and instr_err_o stable.
//  Simultaneous events
//   - Pop and push in the same cycle: pop first, then append behind the remaining entries.
//   - The count<=1 rule guarantees count<=3.
//   - flush_i has priority over both push and pop:
//     - count<=0, pc<=flush_pc_i & ~1, fetch_addr_o<={flush_pc_i[31:2],2'b00}, skip_low<=flush_pc_i[1].
//     - No fetch is accepted in the flush cycle; any presented word is dropped by the fetch unit.
//   - Consecutive flush cycles: the last target wins.
//   - Reset mid-instruction (e.g. upper half pending) discards everything; restart at RESET_PC.
//  Boundary conditions
//   - Empty queue: instr_valid_o=0.
//   - Uncompressed head with count==1 and no err: instr_valid_o=0 until the next word arrives.
//   - Full (count>=2): fetch_ready_o=0.
// TESTING
//  1. Reset, RESET_PC=0x80; words 0x00000513, 0x00100593:
//     -> two 32-bit instrs, PC 0x80 and 0x84; fetch_addr_o 0x80 -> 0x88.
//  2. Word 0x45014581 (c.li a1,0; c.li a0,0):
//     -> instr 0x00004581 @0x80, then 0x00004501 @0x82; valid the cycle after accept.
//  3. Words 0x05134501, 0x00000000:
//     -> 0x00004501 @0x80; straddling 0x00000513 @0x82 is valid only after the second word.
//  4. flush_i with flush_pc_i=0x102, then word 0x4505xxxx:
//     -> low half skipped; instr 0x00004505 @0x102; fetch_addr_o=0x100 after flush.
//  5. Word 0x00000513 with fetch_err_i=1:
//     -> instr_err_o=1 @PC; a straddle whose second word has err also asserts instr_err_o.
//  6. Hold instr_ready_i=0 for 5 cycles, then flush:
//     -> outputs stable while held; fetch_ready_o=0 at count=2; queue empty after flush.

Source files
------------

// File: rtl/fetch_aligner.sv
// Realigns the 32-bit fetch word stream into whole 16/32-bit instructions tagged with their PC.
// A three-entry halfword queue absorbs instructions that straddle a fetch word boundary.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_err_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_err_o
);

    localparam int unsigned HW_W  = 16;
    localparam int unsigned DEPTH = 3;

    logic [HW_W-1:0]  hw_q [DEPTH];
    logic [HW_W-1:0]  hw_d [DEPTH];
    logic [DEPTH-1:0] err_q, err_d;
    logic [1:0]       count_q, count_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic             skip_low_q, skip_low_d;

    logic       head_uncomp;
    logic       avail;
    logic       size4;
    logic       accept;
    logic       xfer;
    logic [1:0] pop_n;
    logic [1:0] rem;
    logic [1:0] rem_p1;

    // An erroneous head is released on its own so a faulting fetch never stalls the pipe.
    assign head_uncomp = (hw_q[0][1:0] == 2'b11);
    assign avail       = (count_q >= 2'd2) || ((count_q != 2'd0) && (!head_uncomp || err_q[0]));
    assign size4       = head_uncomp && (count_q >= 2'd2);

    assign fetch_ready_o = (count_q <= 2'd1) && !flush_i && !rst_i;
    assign instr_valid_o = avail && !flush_i;
    assign accept        = fetch_valid_i && fetch_ready_o;
    assign xfer          = instr_valid_o && instr_ready_i;

    assign instr_o      = size4 ? {hw_q[1], hw_q[0]} : {16'h0000, hw_q[0]};
    assign instr_err_o  = err_q[0] || (size4 && err_q[1]);
    assign instr_pc_o   = pc_q;
    assign fetch_addr_o = fetch_addr_q;

    // Pop the consumed halfwords first, then append the accepted word behind what remains.
    always_comb begin
        hw_d         = hw_q;
        err_d        = err_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        skip_low_d   = skip_low_q;
        pop_n        = xfer ? (size4 ? 2'd2 : 2'd1) : 2'd0;
        rem          = count_q - pop_n;
        rem_p1       = rem + 2'd1;
        count_d      = rem;

        if (pop_n == 2'd1) begin
            hw_d[0]  = hw_q[1];
            hw_d[1]  = hw_q[2];
            err_d[0] = err_q[1];
            err_d[1] = err_q[2];
        end else if (pop_n == 2'd2) begin
            hw_d[0]  = hw_q[2];
            err_d[0] = err_q[2];
        end

        if (xfer) begin
            pc_d = pc_q + (size4 ? 32'd4 : 32'd2);
        end

        if (accept) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
            if (skip_low_q) begin
                hw_d[rem]  = fetch_rdata_i[31:16];
                err_d[rem] = fetch_err_i;
                count_d    = rem_p1;
                skip_low_d = 1'b0;
            end else begin
                hw_d[rem]     = fetch_rdata_i[15:0];
                err_d[rem]    = fetch_err_i;
                hw_d[rem_p1]  = fetch_rdata_i[31:16];
                err_d[rem_p1] = fetch_err_i;
                count_d       = rem + 2'd2;
            end
        end

        if (flush_i) begin
            count_d      = 2'd0;
            pc_d         = flush_pc_i & ~32'd1;
            fetch_addr_d = flush_pc_i & ~32'd3;
            skip_low_d   = flush_pc_i[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hw_q         <= '{default: '0};
            err_q        <= '0;
            count_q      <= 2'd0;
            pc_q         <= RESET_PC;
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            skip_low_q   <= RESET_PC[1];
        end else begin
            hw_q         <= hw_d;
            err_q        <= err_d;
            count_q      <= count_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            skip_low_q   <= skip_low_d;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a halfword-queue model of the aligner.
module tb_fetch_aligner;

    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] fetch_addr_o;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i;
    logic        fetch_err_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_err_o;

    fetch_aligner #(.RESET_PC(RST_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fetch_addr_o  (fetch_addr_o),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_rdata_i (fetch_rdata_i),
        .fetch_err_i   (fetch_err_i),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_err_o   (instr_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } hw_t;

    hw_t         mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_fa;
    logic        m_skip;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outputs follow from the queue contents; then the cycle's events advance it.
    always @(negedge clk_i) begin : model
        int          n;
        int          sz;
        logic        e_v;
        logic        e_r;
        logic [31:0] e_ins;
        logic        e_err;
        if (rst_i) begin
            mq.delete();
            m_pc   = RST_PC;
            m_fa   = {RST_PC[31:2], 2'b00};
            m_skip = RST_PC[1];
            chk("rst_valid", 32'(instr_valid_o), 32'd0);
            chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd0);
        end else begin
            n  = mq.size();
            sz = 0;
            if (n >= 1) begin
                if (mq[0].d[1:0] != 2'b11) sz = 2;
                else if (n >= 2)           sz = 4;
                else if (mq[0].e)          sz = 2;
            end
            e_v = (sz != 0) && !flush_i;
            e_r = (n <= 1) && !flush_i;
            chk("m_valid", 32'(instr_valid_o), 32'(e_v));
            chk("m_fetch_ready", 32'(fetch_ready_o), 32'(e_r));
            chk("m_fetch_addr", fetch_addr_o, m_fa);
            if (e_v) begin
                e_ins = (sz == 4) ? {mq[1].d, mq[0].d} : {16'h0000, mq[0].d};
                e_err = mq[0].e || (sz == 4 && mq[1].e);
                chk("m_instr", instr_o, e_ins);
                chk("m_pc", instr_pc_o, m_pc);
                chk("m_err", 32'(instr_err_o), 32'(e_err));
            end
            if (flush_i) begin
                mq.delete();
                m_pc   = flush_pc_i & ~32'd1;
                m_fa   = flush_pc_i & ~32'd3;
                m_skip = flush_pc_i[1];
            end else begin
                if (e_v && instr_ready_i) begin
                    repeat (sz / 2) void'(mq.pop_front());
                    m_pc = m_pc + 32'(sz);
                end
                if (fetch_valid_i && e_r) begin
                    if (!m_skip) mq.push_back(hw_t'{d: fetch_rdata_i[15:0], e: fetch_err_i});
                    mq.push_back(hw_t'{d: fetch_rdata_i[31:16], e: fetch_err_i});
                    m_skip = 1'b0;
                    m_fa   = m_fa + 32'd4;
                end
            end
        end
    end

    task automatic step(input logic fv, input logic [31:0] wd, input logic fe,
                        input logic fl, input logic [31:0] fpc, input logic rdy);
        @(posedge clk_i);
        #1;
        rst_i         = 1'b0;
        fetch_valid_i = fv;
        fetch_rdata_i = wd;
        fetch_err_i   = fe;
        flush_i       = fl;
        flush_pc_i    = fpc;
        instr_ready_i = rdy;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i         = 1'b1;
        fetch_valid_i = 1'b0;
        fetch_err_i   = 1'b0;
        flush_i       = 1'b0;
        instr_ready_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic chk_out(input string name, input logic [31:0] ins, input logic [31:0] pc,
                           input logic err);
        chk({name, "_valid"}, 32'(instr_valid_o), 32'd1);
        chk({name, "_instr"}, instr_o, ins);
        chk({name, "_pc"}, instr_pc_o, pc);
        chk({name, "_err"}, 32'(instr_err_o), 32'(err));
    endtask

    initial begin
        rst_i         = 1'b1;
        fetch_valid_i = 1'b0;
        fetch_rdata_i = 32'd0;
        fetch_err_i   = 1'b0;
        flush_i       = 1'b0;
        flush_pc_i    = 32'd0;
        instr_ready_i = 1'b0;

        // Two 32-bit instructions
        do_reset();
        chk("t1_reset_addr", fetch_addr_o, 32'h80);
        step(1'b1, 32'h0000_0513, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("t1_ready", 32'(fetch_ready_o), 32'd1);
        chk("t1_empty", 32'(instr_valid_o), 32'd0);
        step(1'b1, 32'h0010_0593, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t1_a", 32'h0000_0513, 32'h80, 1'b0);
        chk("t1_full_ready", 32'(fetch_ready_o), 32'd0);
        step(1'b1, 32'h0010_0593, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t1_b", 32'h0010_0593, 32'h84, 1'b0);
        chk("t1_addr", fetch_addr_o, 32'h88);

        // Two compressed instructions in one word
        do_reset();
        step(1'b1, 32'h4501_4581, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t2_a", 32'h0000_4581, 32'h80, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t2_b", 32'h0000_4501, 32'h82, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("t2_drained", 32'(instr_valid_o), 32'd0);

        // Straddling 32-bit instruction
        do_reset();
        step(1'b1, 32'h0513_4501, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t3_a", 32'h0000_4501, 32'h80, 1'b0);
        step(1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("t3_wait_upper", 32'(instr_valid_o), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t3_b", 32'h0000_0513, 32'h82, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t3_c", 32'h0000_0000, 32'h86, 1'b0);

        // Flush to a halfword-aligned target
        do_reset();
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
        chk("t4_flush_valid", 32'(instr_valid_o), 32'd0);
        step(1'b1, 32'h4505_1234, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("t4_addr", fetch_addr_o, 32'h100);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t4_a", 32'h0000_4505, 32'h102, 1'b0);

        // Bus errors, including on the upper half of a straddle
        do_reset();
        step(1'b1, 32'h0000_0513, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 32'h0513_0001, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t5_a", 32'h0000_0513, 32'h80, 1'b1);
        step(1'b1, 32'h0513_0001, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'd0, 1'b1);
        chk_out("t5_b", 32'h0000_0001, 32'h84, 1'b0);
        step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t5_c", 32'h0000_0513, 32'h86, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_out("t5_d", 32'h0000_0000, 32'h8A, 1'b1);

        // Backpressure then flush
        do_reset();
        step(1'b1, 32'h0000_0513, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h0010_0593, 1'b0, 1'b0, 32'd0, 1'b0);
            chk_out("t6_hold", 32'h0000_0513, 32'h80, 1'b0);
            chk("t6_full", 32'(fetch_ready_o), 32'd0);
        end
        step(1'b1, 32'h0010_0593, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
        chk("t6_flush_valid", 32'(instr_valid_o), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("t6_empty", 32'(instr_valid_o), 32'd0);
        chk("t6_ready", 32'(fetch_ready_o), 32'd1);
        chk("t6_addr", fetch_addr_o, 32'h200);

        // Reset with the upper half of a straddle still pending
        do_reset();
        step(1'b1, 32'h0513_4501, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        do_reset();
        chk("t7_addr", fetch_addr_o, 32'h80);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("t7_empty", 32'(instr_valid_o), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] w;
            logic [31:0] fpc;
            w = $urandom;
            if ($urandom_range(1, 0) == 1) w[1:0] = 2'b11;
            if ($urandom_range(1, 0) == 1) w[17:16] = 2'b11;
            fpc = $urandom & 32'h0000_0FFF;
            if ($urandom_range(7, 0) == 0) fpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            if ($urandom_range(299, 0) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(9, 0) < 7, w, $urandom_range(19, 0) == 0,
                     $urandom_range(99, 0) < 3, fpc, $urandom_range(3, 0) != 0);
            end
        end

        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
